// File: rtl/gen_fir_pkg.sv
// Shared definitions for the programmable generator/FIR chain: FSM encodings,
// default coefficient set and output saturation bounds.
package gen_fir_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Pass-through set: tap 0 at the largest positive coefficient, rest zero
  function automatic int default_coef(input int unsigned tap, input int unsigned nb_coef);
    return (tap == 0) ? ((1 << (nb_coef - 1)) - 1) : 0;
  endfunction

  function automatic int sat_max(input int unsigned nb);
    return (1 << (nb - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned nb);
    return -(1 << (nb - 1));
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Run-time programmable FIR coefficient register file with a flat parallel
// read bus; resets to the pass-through set.
module fir_coef_bank
  import gen_fir_pkg::*;
#(
  parameter int unsigned N_TAPS  = 8,
  parameter int unsigned NB_COEF = 8,
  parameter int unsigned NB_ADDR = 3
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_we,
  input  logic [NB_ADDR-1:0]        i_addr,
  input  logic [NB_COEF-1:0]        i_data,
  output logic [N_TAPS*NB_COEF-1:0] o_coefs
);

  logic [NB_COEF-1:0] coef [N_TAPS];

  // Out-of-range tap indices are dropped
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int unsigned t = 0; t < N_TAPS; t++) begin
        coef[t] <= NB_COEF'(default_coef(t, NB_COEF));
      end
    end else if (i_we && (32'(i_addr) < N_TAPS)) begin
      coef[i_addr] <= i_data;
    end
  end

  for (genvar t = 0; t < N_TAPS; t++) begin : g_flat
    assign o_coefs[t*NB_COEF +: NB_COEF] = coef[t];
  end

endmodule

// File: rtl/gen_fir_prog.sv
// Channel-selectable generator feed into a programmable FIR with saturated,
// strobed output; a channel switch flushes and refills the delay line.
module gen_fir_prog
  import gen_fir_pkg::*;
#(
  parameter int unsigned NB_SEL      = 2,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned NB_DATA_IN  = 8,
  parameter int unsigned NB_COEF     = 8,
  parameter int unsigned N_TAPS      = 8,
  parameter int unsigned NB_ADDR     = 3,
  parameter int unsigned NB_DATA_OUT = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [NB_SEL-1:0]          i_sel,
  input  logic [N_CH*NB_DATA_IN-1:0] i_signals,
  input  logic                       i_coef_we,
  input  logic [NB_ADDR-1:0]         i_coef_addr,
  input  logic [NB_COEF-1:0]         i_coef_data,
  output logic [NB_DATA_OUT-1:0]     o_signal,
  output logic                       o_valid,
  output logic                       o_sat,
  output logic                       o_busy
);

  localparam int unsigned NB_PROD = NB_DATA_IN + NB_COEF;
  localparam int unsigned NB_ACC  = NB_PROD + NB_ADDR;
  localparam int unsigned NB_RES  = NB_ACC - (NB_COEF - 1);
  localparam logic signed [NB_RES-1:0] RES_MAX  = NB_RES'(sat_max(NB_DATA_OUT));
  localparam logic signed [NB_RES-1:0] RES_MIN  = NB_RES'(sat_min(NB_DATA_OUT));
  localparam logic        [NB_ADDR-1:0] CNT_LAST = NB_ADDR'(N_TAPS - 1);

  state_t                         state, state_next;
  logic [NB_SEL-1:0]              r_sel;
  logic [NB_ADDR-1:0]             cnt, cnt_next;
  logic                           sel_change;
  logic                           dl_clear, dl_shift, fire, v1;
  logic signed [NB_DATA_IN-1:0]   sample;
  logic signed [NB_DATA_IN-1:0]   dl   [N_TAPS];
  logic signed [NB_COEF-1:0]      coef [N_TAPS];
  logic signed [NB_PROD-1:0]      prod [N_TAPS];
  logic [N_TAPS*NB_COEF-1:0]      coefs_flat;
  logic signed [NB_ACC-1:0]       acc;
  logic signed [NB_RES-1:0]       res;
  logic signed [NB_DATA_OUT-1:0]  sig_c;
  logic                           sat_c;

  fir_coef_bank #(
    .N_TAPS  (N_TAPS),
    .NB_COEF (NB_COEF),
    .NB_ADDR (NB_ADDR)
  ) u_coef_bank (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_we    (i_coef_we),
    .i_addr  (i_coef_addr),
    .i_data  (i_coef_data),
    .o_coefs (coefs_flat)
  );

  for (genvar t = 0; t < N_TAPS; t++) begin : g_coef
    assign coef[t] = coefs_flat[t*NB_COEF +: NB_COEF];
  end

  assign sel_change = (i_sel != r_sel);

  // Unused select codes fall back to channel 0
  always_comb begin
    sample = i_signals[NB_DATA_IN-1:0];
    for (int k = 1; k < N_CH; k++) begin
      if (int'(r_sel) == k) sample = i_signals[k*NB_DATA_IN +: NB_DATA_IN];
    end
  end

  // FSM state register; busy tracks the next state so it drops on RUN entry
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state  <= ST_FILL;
      o_busy <= 1'b1;
    end else begin
      state  <= state_next;
      o_busy <= (state_next != ST_RUN);
    end
  end

  always_comb begin
    state_next = state;
    if (sel_change) begin
      state_next = ST_FLUSH;
    end else begin
      case (state)
        ST_FLUSH: state_next = ST_FILL;
        ST_FILL:  if (i_enable && (cnt == CNT_LAST)) state_next = ST_RUN;
        default:  state_next = state;
      endcase
    end
  end

  // FLUSH clears the line and takes its own sample as the first of the refill
  always_comb begin
    dl_clear = 1'b0;
    dl_shift = 1'b0;
    fire     = 1'b0;
    cnt_next = cnt;
    if (!sel_change) begin
      case (state)
        ST_FLUSH: begin
          dl_clear = 1'b1;
          dl_shift = i_enable;
          cnt_next = i_enable ? NB_ADDR'(1) : '0;
        end
        ST_FILL: begin
          if (i_enable) begin
            dl_shift = 1'b1;
            if (cnt == CNT_LAST) begin
              fire     = 1'b1;
              cnt_next = '0;
            end else begin
              cnt_next = cnt + NB_ADDR'(1);
            end
          end
        end
        ST_RUN: begin
          dl_shift = i_enable;
          fire     = i_enable;
        end
        default: ;
      endcase
    end
  end

  // Full-precision MAC, floor shift back to the input scale, then clip
  always_comb begin
    acc = '0;
    for (int t = 0; t < N_TAPS; t++) begin
      prod[t] = dl[t] * coef[t];
      acc     = acc + NB_ACC'(prod[t]);
    end
    res   = NB_RES'(acc >>> (NB_COEF - 1));
    sig_c = NB_DATA_OUT'(res);
    sat_c = 1'b0;
    if (res > RES_MAX) begin
      sig_c = NB_DATA_OUT'(RES_MAX);
      sat_c = 1'b1;
    end else if (res < RES_MIN) begin
      sig_c = NB_DATA_OUT'(RES_MIN);
      sat_c = 1'b1;
    end
  end

  // A select change squashes the in-flight output so FLUSH never shows a valid
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sel    <= '0;
      cnt      <= '0;
      v1       <= 1'b0;
      o_signal <= '0;
      o_valid  <= 1'b0;
      o_sat    <= 1'b0;
      for (int t = 0; t < N_TAPS; t++) dl[t] <= '0;
    end else begin
      if (sel_change) r_sel <= i_sel;
      cnt     <= cnt_next;
      v1      <= fire;
      o_valid <= v1 && !sel_change;
      if (v1 && !sel_change) begin
        o_signal <= sig_c;
        o_sat    <= sat_c;
      end
      if (dl_shift) begin
        dl[0] <= sample;
        for (int t = 1; t < N_TAPS; t++) dl[t] <= dl_clear ? '0 : dl[t-1];
      end else if (dl_clear) begin
        for (int t = 0; t < N_TAPS; t++) dl[t] <= '0;
      end
    end
  end

endmodule

// File: doc/gen_fir_prog.md
# gen_fir_prog

Parametrised successor to the generator/FIR chain. The block selects one of `N_CH` signed generator channels and filters it through an `N_TAPS` FIR whose coefficients are run-time programmable. It produces a saturated output with a per-sample valid strobe. Each channel switch triggers a flush-and-refill sequence, so the output never mixes samples from two sources. It sits between the signal generators and the log memory.

## Interface
- `NB_SEL`, 2, channel select width
- `N_CH`, 4, number of input channels (≤ 2**NB_SEL)
- `NB_DATA_IN`, 8, input sample width, signed S(NB_DATA_IN, NB_DATA_IN-1)
- `NB_COEF`, 8, coefficient width, signed S(NB_COEF, NB_COEF-1)
- `N_TAPS`, 8, filter length (≥ 2)
- `NB_ADDR`, 3, coefficient address width, clog2(N_TAPS)
- `NB_DATA_OUT`, 8, output width, signed S(NB_DATA_OUT, NB_DATA_OUT-1)

Ports:
- `i_clock`  in  1  single clock; all state on rising edge
- `i_reset`  in  1  synchronous, active-low reset
- `i_enable`  in  1  sample strobe; one sample accepted per cycle while high
- `i_sel`  in  NB_SEL  channel select; values ≥ N_CH select channel 0
- `i_signals`  in  N_CH*NB_DATA_IN  packed channels; ch k at [k*NB_DATA_IN +: NB_DATA_IN]
- `i_coef_we`  in  1  coefficient write strobe
- `i_coef_addr`  in  NB_ADDR  tap index; values ≥ N_TAPS are ignored
- `i_coef_data`  in  NB_COEF  coefficient value
- `o_signal`  out  NB_DATA_OUT  filtered sample, held between valids
- `o_valid`  out  1  one-cycle pulse per produced output
- `o_sat`  out  1  set when the current `o_signal` was clipped; updated with `o_valid`
- `o_busy`  out  1  high in FLUSH/FILL

## Operation
- Registered select `r_sel`. A cycle with `i_sel != r_sel` loads `r_sel` and enters FLUSH.
  - Any sample presented in that cycle is discarded.
- FSM states:
  - **FLUSH** (exactly 1 cycle, independent of `i_enable`): clears the delay line and the fill counter, then goes to FILL.
  - **FILL**: accepted samples shift into the delay line. When the N_TAPS-th sample is accepted, the FSM moves to RUN. The output for that sample is the first valid one.
  - **RUN**: each accepted sample produces one output.
- A select change in any state (including FILL) goes to FLUSH and restarts the sequence.
- Delay line: tap 0 holds the newest sample. Only shifts when `i_enable` = 1.
- Arithmetic:
  - Products are NB_DATA_IN+NB_COEF bits.
  - Accumulator is NB_DATA_IN+NB_COEF+NB_ADDR bits, full precision with no intermediate wrap.
  - Result = accumulator >>> (NB_COEF-1), arithmetic shift, truncation toward −∞.
  - The result then saturates to [−2^(NB_DATA_OUT−1), 2^(NB_DATA_OUT−1)−1]; `o_sat` = 1 when clipped.
- Coefficient bank:
  - Written in any state when `i_coef_we` = 1. Writes do not affect the FSM or the delay line.
  - A new value is used for any output computed from the cycle after the write.
- `i_enable` = 0: delay line, counter and outputs hold. FSM transitions caused by a select change still occur.
- Reset (`i_reset` = 0 at an edge, at any time including mid-FILL):
  - `o_signal` = 0, `o_valid` = 0, `o_sat` = 0, `o_busy` = 1.
  - Delay line is zeroed, `r_sel` = 0, state = FILL, count = 0.
  - Coefficients reset to tap 0 = 2^(NB_COEF−1)−1 and all other taps = 0 (pass-through).

## Timing
- Pipeline has 2 stages: delay-line register, then output register.
- Latency: a sample with `i_enable` = 1 in cycle n gives `o_signal`/`o_valid`/`o_sat` updated at the edge ending cycle n+1, visible in cycle n+2.
- `o_valid` is high for exactly one cycle per RUN-accepted sample (including the sample that completes FILL). It is never high in FLUSH.
- After a select change in cycle n: the earliest `o_valid` follows the N_TAPS-th enabled sample after cycle n.
  - With continuous enable, the first valid appears N_TAPS+2 cycles after cycle n.
- `o_busy` is registered with the state and drops when RUN is entered.

## Structure
- Shared package/header `gen_fir_pkg` contains:
  - FSM encodings ST_FLUSH, ST_FILL, ST_RUN.
  - The default-coefficient function.
  - Saturation bounds derived from NB_DATA_OUT.
- One sub-module, `fir_coef_bank`: N_TAPS × NB_COEF register file with a synchronous write port, a flat parallel read bus, and reset to the default set.
- The delay line, multiply-accumulate, saturation and FSM stay in `gen_fir_prog`.

## Test plan
1. **Pass-through fill.** Reset, sel=0, ch0 = 64, enable held high → `o_valid` first pulses 10 cycles after reset release with `o_signal` = 63, then every cycle at 63; `o_sat` = 0.
2. **Averaging coefficients.** Write all 8 taps = 16 (0.125), then ch0 = 64 constant → settled output 64.
3. **Saturation.** Write all taps = 127.
   - ch1 = 127 → `o_signal` = 127, `o_sat` = 1.
   - ch1 = −128 → `o_signal` = −128, `o_sat` = 1.
4. **Channel switch.** sel 0→2 mid-RUN (ch0 = 64, ch2 = −32, pass-through coefficients) → `o_valid` low for 1+8 cycles, `o_busy` high; first valid is −32; no mixed value is ever flagged valid.
5. **Gated enable.** Enable at 50% duty in RUN → exactly one `o_valid` per enabled cycle, 2-cycle latency, output held in between.
6. **Reset mid-FILL.** Assert `i_reset` = 0 after 4 samples → next edge all outputs reset; a previously written coefficient set reverts to pass-through (scenario 1 result repeats).
